// File: rtl/evt_timeout_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : evt_mon_pkg
// Purpose  : Shared types and constants for the event/timeout monitor.
//            - mon_state_t : per-channel FSM state (IDLE, WAIT)
//            - MAX_CH      : upper bound on the number of channels
//            - sel_width() : width of the channel-select bus (never below 1)
// Revision : 1.0 - initial release
// ============================================================================
package evt_mon_pkg;

    localparam int MAX_CH = 16;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mon_state_t;

    // A single-channel build still needs a 1-bit select port.
    function automatic int sel_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage : evt_mon_pkg
`default_nettype wire

// File: rtl/evt_timeout_mon_if.sv
`default_nettype none
// ============================================================================
// Module   : evt_timeout_mon_if
// Purpose  : Bundle of the monitor's request/response signals.
//   sig       [NUM_CH]  monitored signals (clk-synchronous)
//   arm       [NUM_CH]  one-cycle arm strobe per channel
//   pol                 edge polarity captured on arm (1 rising, 0 falling)
//   limit     [CNT_W]   timeout in cycles captured on arm (0 -> 1)
//   clr_err             clears the sticky error flag
//   rd_sel    [SEL_W]   channel select for rd_cycles
//   busy/hit/tmo        per-channel status and one-cycle result pulses
//   err                 sticky OR of all timeout pulses
//   rd_cycles [CNT_W]   last result count of channel rd_sel
//   master : drives requests (system side);  slave : the monitor
// Revision : 1.0 - initial release
// ============================================================================
interface evt_timeout_mon_if
    import evt_mon_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
);
    localparam int SEL_W = sel_width(NUM_CH);

    logic [NUM_CH-1:0] sig;
    logic [NUM_CH-1:0] arm;
    logic              pol;
    logic [CNT_W-1:0]  limit;
    logic              clr_err;
    logic [SEL_W-1:0]  rd_sel;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] tmo;
    logic              err;
    logic [CNT_W-1:0]  rd_cycles;

    modport master (
        output sig, arm, pol, limit, clr_err, rd_sel,
        input  busy, hit, tmo, err, rd_cycles
    );

    modport slave (
        input  sig, arm, pol, limit, clr_err, rd_sel,
        output busy, hit, tmo, err, rd_cycles
    );

endinterface : evt_timeout_mon_if
`default_nettype wire

// File: rtl/evt_timeout_mon_ch.sv
`default_nettype none
// ============================================================================
// Module   : evt_mon_ch
// Purpose  : One monitor channel: edge detector, IDLE/WAIT FSM, cycle
//            counter, captured polarity/limit and held result count.
//   clk, rst_n   clock, asynchronous active-low reset
//   sig_i        monitored signal
//   arm_i        arm strobe (restarts the channel when already waiting)
//   pol_i        polarity to capture on arm (1 rising, 0 falling)
//   limit_i      timeout to capture on arm (0 treated as 1)
//   busy_o       channel is waiting
//   hit_o/tmo_o  one-cycle result pulses
//   tmo_set_o    timeout decided this cycle (tmo_o rises next cycle)
//   res_o        last result count
// Revision : 1.0 - initial release
// ============================================================================
module evt_mon_ch
    import evt_mon_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_i,
    input  logic             arm_i,
    input  logic             pol_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             busy_o,
    output logic             hit_o,
    output logic             tmo_o,
    output logic             tmo_set_o,
    output logic [CNT_W-1:0] res_o
);

    mon_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lim_q, lim_d;
    logic [CNT_W-1:0] res_q, res_d;
    logic             pol_q, pol_d;
    logic             hit_q, hit_d;
    logic             tmo_q, tmo_d;
    logic             sig_ff_q;
    logic             edge_w;

    assign edge_w = pol_q ? (sig_i & ~sig_ff_q) : (~sig_i & sig_ff_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            lim_q    <= '0;
            res_q    <= '0;
            pol_q    <= 1'b0;
            hit_q    <= 1'b0;
            tmo_q    <= 1'b0;
            sig_ff_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lim_q    <= lim_d;
            res_q    <= res_d;
            pol_q    <= pol_d;
            hit_q    <= hit_d;
            tmo_q    <= tmo_d;
            sig_ff_q <= sig_i;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lim_d   = lim_q;
        res_d   = res_q;
        pol_d   = pol_q;
        hit_d   = 1'b0;
        tmo_d   = 1'b0;

        // Arm has top priority in both states; in WAIT it discards any edge
        // or limit expiry of the same cycle and restarts the count.
        if (arm_i) begin
            state_d = WAIT;
            pol_d   = pol_i;
            lim_d   = (limit_i == '0) ? CNT_W'(1) : limit_i;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: ;
                WAIT: begin
                    if (edge_w) begin
                        res_d   = cnt_q;
                        hit_d   = 1'b1;
                        state_d = IDLE;
                    end else if (cnt_q == lim_q - CNT_W'(1)) begin
                        res_d   = lim_q;
                        tmo_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy_o    = (state_q == WAIT);
    assign hit_o     = hit_q;
    assign tmo_o     = tmo_q;
    assign tmo_set_o = tmo_d;
    assign res_o     = res_q;

endmodule : evt_mon_ch
`default_nettype wire

// File: rtl/evt_timeout_mon.sv
`default_nettype none
// ============================================================================
// Module   : evt_timeout_mon
// Purpose  : Multi-channel event/timeout monitor. Each channel is armed with
//            an edge polarity and a cycle limit and reports a hit (edge seen,
//            with elapsed count) or a timeout.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         evt_timeout_mon_if slave: sig/arm/pol/limit/clr_err/rd_sel
//               in, busy/hit/tmo/err/rd_cycles out
// Revision : 1.0 - initial release
// ============================================================================
module evt_timeout_mon
    import evt_mon_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    evt_timeout_mon_if.slave   bus
);

    localparam int SEL_W = sel_width(NUM_CH);

    generate
        if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
            $error("evt_timeout_mon: NUM_CH must be 1..%0d", MAX_CH);
        end
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("evt_timeout_mon: CNT_W must be at least 1");
        end
    endgenerate

    logic [CNT_W-1:0]  res_w [NUM_CH];
    logic [NUM_CH-1:0] tmo_set_w;
    logic              err_q, err_d;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            evt_mon_ch #(
                .CNT_W (CNT_W)
            ) u_ch (
                .clk       (clk),
                .rst_n     (rst_n),
                .sig_i     (bus.sig[g]),
                .arm_i     (bus.arm[g]),
                .pol_i     (bus.pol),
                .limit_i   (bus.limit),
                .busy_o    (bus.busy[g]),
                .hit_o     (bus.hit[g]),
                .tmo_o     (bus.tmo[g]),
                .tmo_set_o (tmo_set_w[g]),
                .res_o     (res_w[g])
            );
        end
    endgenerate

    // err rises together with the tmo pulse; a clear arriving while a tmo
    // pulse is pending or visible loses against it.
    always_comb begin
        err_d = (|tmo_set_w) | (|bus.tmo) | (err_q & ~bus.clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;

    // Out-of-range selects (non power-of-two NUM_CH) read as zero.
    always_comb begin
        bus.rd_cycles = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.rd_sel == SEL_W'(i)) begin
                bus.rd_cycles = res_w[i];
            end
        end
    end

endmodule : evt_timeout_mon
`default_nettype wire

// File: tb/tb_evt_timeout_mon.sv
`default_nettype none
// ============================================================================
// Module   : tb_evt_timeout_mon
// Purpose  : Self-checking bench for evt_timeout_mon: directed scenarios with
//            literal expectations plus randomized traffic, all outputs
//            compared every cycle against a timestamp-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_evt_timeout_mon;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;

    logic clk;
    logic rst_n;

    evt_timeout_mon_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    evt_timeout_mon #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: a waiting channel remembers the absolute cycle of its
    // first WAIT cycle; elapsed = now - start, deadline = start + lim - 1.
    bit m_wait [NUM_CH];
    int m_start[NUM_CH];
    int m_lim  [NUM_CH];
    bit m_pol  [NUM_CH];
    int m_res  [NUM_CH];
    bit m_hit  [NUM_CH];
    bit m_tmo  [NUM_CH];
    bit m_prev [NUM_CH];
    bit m_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_wait[c] = 0; m_start[c] = 0; m_lim[c] = 0; m_pol[c] = 0;
            m_res[c]  = 0; m_hit[c]   = 0; m_tmo[c] = 0; m_prev[c] = 0;
        end
        m_err = 0;
    endtask

    // Consumes the inputs of cycle 'cyc' and yields the outputs of cyc+1.
    task automatic model_step();
        bit any_new_tmo = 0;
        bit any_old_tmo = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            bit s   = bus.sig[c];
            bit rose = s && !m_prev[c];
            bit fell = !s && m_prev[c];
            bit edge_seen = m_pol[c] ? rose : fell;
            bit nh = 0, nt = 0;
            if (m_tmo[c]) any_old_tmo = 1;
            if (bus.arm[c]) begin
                m_wait[c]  = 1;
                m_start[c] = cyc + 1;
                m_lim[c]   = (bus.limit == 0) ? 1 : int'(bus.limit);
                m_pol[c]   = bus.pol;
            end else if (m_wait[c]) begin
                if (edge_seen) begin
                    m_res[c] = cyc - m_start[c];
                    nh = 1; m_wait[c] = 0;
                end else if (cyc == m_start[c] + m_lim[c] - 1) begin
                    m_res[c] = m_lim[c];
                    nt = 1; m_wait[c] = 0;
                end
            end
            m_prev[c] = s;
            m_hit[c]  = nh;
            m_tmo[c]  = nt;
            if (nt) any_new_tmo = 1;
        end
        m_err = any_new_tmo || any_old_tmo || (m_err && !bus.clr_err);
    endtask

    task automatic compare();
        logic [NUM_CH-1:0] eb, eh, et;
        for (int c = 0; c < NUM_CH; c++) begin
            eb[c] = m_wait[c]; eh[c] = m_hit[c]; et[c] = m_tmo[c];
        end
        chk("busy", 32'(bus.busy), 32'(eb));
        chk("hit",  32'(bus.hit),  32'(eh));
        chk("tmo",  32'(bus.tmo),  32'(et));
        chk("err",  32'(bus.err),  32'(m_err));
        chk("rd_cycles", 32'(bus.rd_cycles), 32'(m_res[bus.rd_sel]));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        cyc++;
        @(negedge clk);
        compare();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.sig     = '0;
        bus.arm     = '0;
        bus.pol     = 1'b0;
        bus.limit   = '0;
        bus.clr_err = 1'b0;
        bus.rd_sel  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 32'h0);
        chk("reset_err",  32'(bus.err),  32'h0);
        chk("reset_rd",   32'(bus.rd_cycles), 32'h0);
        compare();
        rst_n = 1'b1;
        tick();

        // 1: ch0 rising, limit 10, edge at cycle 4 -> hit at 5, count 3
        bus.pol = 1'b1; bus.limit = 16'd10; bus.arm = 4'b0001; bus.rd_sel = 2'd0;
        tick();
        bus.arm = '0;
        chk("t1_busy", 32'(bus.busy[0]), 32'h1);
        run(3);
        bus.sig[0] = 1'b1;
        tick();
        chk("t1_hit", 32'(bus.hit[0]), 32'h1);
        chk("t1_rd",  32'(bus.rd_cycles), 32'd3);
        chk("t1_err", 32'(bus.err), 32'h0);
        tick();
        chk("t1_hit_gone", 32'(bus.hit[0]), 32'h0);

        // 2: ch1 falling, limit 5, sig held high -> tmo at arm+6
        bus.sig[1] = 1'b1;
        tick();
        bus.pol = 1'b0; bus.limit = 16'd5; bus.arm = 4'b0010; bus.rd_sel = 2'd1;
        tick();
        bus.arm = '0;
        run(4);
        chk("t2_no_tmo_early", 32'(bus.tmo[1]), 32'h0);
        tick();
        chk("t2_tmo", 32'(bus.tmo[1]), 32'h1);
        chk("t2_rd",  32'(bus.rd_cycles), 32'd5);
        chk("t2_err", 32'(bus.err), 32'h1);
        tick();
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        chk("t2_err_clr", 32'(bus.err), 32'h0);

        // 3: edge on the last WAIT cycle (limit 3, k=2) -> hit only
        bus.sig[0] = 1'b0;
        tick();
        bus.pol = 1'b1; bus.limit = 16'd3; bus.arm = 4'b0001; bus.rd_sel = 2'd0;
        tick();
        bus.arm = '0;
        run(2);
        bus.sig[0] = 1'b1;
        tick();
        chk("t3_hit", 32'(bus.hit[0]), 32'h1);
        chk("t3_tmo", 32'(bus.tmo[0]), 32'h0);
        chk("t3_rd",  32'(bus.rd_cycles), 32'd2);
        tick();
        chk("t3_no_late_tmo", 32'(bus.tmo[0]), 32'h0);

        // 4: ch2 re-armed at k=4 with limit 2 -> tmo 3 cycles after re-arm
        bus.pol = 1'b1; bus.limit = 16'd10; bus.arm = 4'b0100; bus.rd_sel = 2'd2;
        tick();
        bus.arm = '0;
        run(4);
        bus.limit = 16'd2; bus.arm = 4'b0100;
        tick();
        bus.arm = '0;
        chk("t4_no_pulse", 32'({bus.hit[2], bus.tmo[2]}), 32'h0);
        chk("t4_busy", 32'(bus.busy[2]), 32'h1);
        tick();
        chk("t4_no_tmo_yet", 32'(bus.tmo[2]), 32'h0);
        tick();
        chk("t4_tmo", 32'(bus.tmo[2]), 32'h1);
        chk("t4_rd",  32'(bus.rd_cycles), 32'd2);

        // 5: edge only in the arm cycle is ignored; limit 0 acts as 1
        bus.sig[3] = 1'b0;
        tick();
        bus.pol = 1'b1; bus.limit = 16'd4; bus.arm = 4'b1000; bus.sig[3] = 1'b1; bus.rd_sel = 2'd3;
        tick();
        bus.arm = '0;
        run(3);
        chk("t5_no_tmo_early", 32'(bus.tmo[3]), 32'h0);
        tick();
        chk("t5_tmo", 32'(bus.tmo[3]), 32'h1);
        chk("t5_rd",  32'(bus.rd_cycles), 32'd4);
        bus.limit = 16'd0; bus.arm = 4'b1000;
        tick();
        bus.arm = '0;
        chk("t5_lim0_busy", 32'(bus.busy[3]), 32'h1);
        tick();
        chk("t5_lim0_tmo", 32'(bus.tmo[3]), 32'h1);
        chk("t5_lim0_rd",  32'(bus.rd_cycles), 32'd1);

        // 6: all channels together, staggered edges; reset on the second pass
        for (int pass = 0; pass < 2; pass++) begin
            bus.sig = '0;
            tick();
            bus.pol = 1'b1; bus.limit = 16'd20; bus.arm = '1;
            tick();
            bus.arm = '0;
            for (int k = 0; k < 10; k++) begin
                if (pass == 1 && k == 4) begin
                    rst_n = 1'b0;
                    model_reset();
                    tick();
                    chk("t6_rst_busy", 32'(bus.busy), 32'h0);
                    chk("t6_rst_err",  32'(bus.err),  32'h0);
                    rst_n = 1'b1;
                end
                for (int c = 0; c < NUM_CH; c++)
                    if (k == 1 + 2 * c) bus.sig[c] = 1'b1;
                tick();
            end
            chk("t6_idle", 32'(bus.busy), 32'h0);
        end

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                bus.arm[c] = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 3) == 0) bus.sig[c] = ~bus.sig[c];
            end
            bus.pol     = 1'($urandom_range(0, 1));
            bus.limit   = 16'($urandom_range(0, 12));
            bus.clr_err = ($urandom_range(0, 7) == 0);
            bus.rd_sel  = 2'($urandom_range(0, NUM_CH - 1));
            if (rst_n && $urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end else begin
                rst_n = 1'b1;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule : tb_evt_timeout_mon
`default_nettype wire
